// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
package pc_seq_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned PC_STEP_DEF = 4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_ISSUE,
        ST_HALTED
    } state_t;

    // True when an instruction address is not word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: instruction memory, decode handoff, redirect and control.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt;
    logic            fault;
    logic [31:0]     fetch_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc, fault, fetch_count,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, fault, fetch_count,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, halt
    );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC candidates: sequential step, redirect/pending target, alignment check.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic [XLEN-1:0] i_pend_target,
    output logic [XLEN-1:0] o_seq_pc,
    output logic [XLEN-1:0] o_redir_pc,
    output logic            o_misaligned
);

    // A live redirect always beats a stored one (latest target wins).
    always_comb begin
        o_seq_pc     = i_pc + XLEN'(PC_STEP);
        o_redir_pc   = i_redirect_valid ? i_redirect_target : i_pend_target;
        o_misaligned = i_redirect_valid && is_misaligned(i_redirect_target[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches via req/ack, presents to decode via valid/ready.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     PC_STEP      = PC_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.master   bus
);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pend;
    logic [XLEN-1:0] r_pend_tgt;
    logic            r_req;
    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_ipc;
    logic            r_fault;
    logic [31:0]     r_count;

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_misaligned;

    pc_next_mux #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_next (
        .i_pc              (r_pc),
        .i_redirect_valid  (bus.redirect_valid),
        .i_redirect_target (bus.redirect_target),
        .i_pend_target     (r_pend_tgt),
        .o_seq_pc          (w_seq_pc),
        .o_redir_pc        (w_redir_pc),
        .o_misaligned      (w_misaligned)
    );

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr_out   = r_instr;
    assign bus.instr_pc    = r_ipc;
    assign bus.fault       = r_fault;
    assign bus.fetch_count = r_count;

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_ipc      <= '0;
            r_fault    <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (w_misaligned) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALTED;
                    end else begin
                        if (bus.redirect_valid) r_pc <= bus.redirect_target;
                        if (bus.halt) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_misaligned) begin
                        r_fault <= 1'b1;
                        r_req   <= 1'b0;
                        r_pend  <= 1'b0;
                        r_state <= ST_HALTED;
                    end else if (bus.imem_ack) begin
                        if (bus.redirect_valid || r_pend) begin
                            // Redirected fetch: drop the word, re-request at the target.
                            r_pc   <= w_redir_pc;
                            r_pend <= 1'b0;
                            if (bus.halt) begin
                                r_req   <= 1'b0;
                                r_state <= ST_HALTED;
                            end
                        end else begin
                            r_instr <= bus.imem_rdata;
                            r_ipc   <= r_pc;
                            r_req   <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end else if (bus.redirect_valid) begin
                        // Request must complete at its original address first.
                        r_pend     <= 1'b1;
                        r_pend_tgt <= bus.redirect_target;
                    end
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) r_count <= r_count + 32'd1;
                    if (w_misaligned) begin
                        r_fault <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= ST_HALTED;
                    end else if (bus.redirect_valid || bus.instr_ready) begin
                        r_pc    <= bus.redirect_valid ? w_redir_pc : w_seq_pc;
                        r_valid <= 1'b0;
                        if (bus.halt) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with a transaction-level PC model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .PC_STEP      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t sb[$];

    // Reference model state (driver side)
    logic [31:0] model_pc;
    logic [31:0] req_exp_addr;
    bit          req_open;
    bit          discard;
    bit          model_halted;
    bit          model_fault;
    bit          halt_lvl;
    int unsigned model_acc;

    // Monitor state
    bit          prev_valid;
    logic [31:0] exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0, 1:    t = {20'h0, 10'($urandom_range(1023)), 2'b00};
            2:       t = 32'hFFFF_FFF8;
            default: t = 32'h0000_0300;
        endcase
        return t;
    endfunction

    // One cycle of stimulus: check outputs, choose inputs, advance the model.
    task automatic step(input int unsigned p_ack, input int unsigned p_ready,
                        input int unsigned p_redir, input bit force_redir = 1'b0,
                        input logic [31:0] force_tgt = '0);
        logic        do_ack, do_ready, do_redir;
        logic [31:0] tgt, rdata;
        @(negedge clk);
        chk("fault", {31'h0, bus.fault}, {31'h0, model_fault});
        if (model_halted) begin
            chk("halted_req", {31'h0, bus.imem_req}, 32'h0);
        end else if (bus.imem_req) begin
            if (!req_open) begin
                req_open     = 1'b1;
                req_exp_addr = model_pc;
            end
            chk("fetch_addr", bus.imem_addr, req_exp_addr);
        end
        do_ack   = bus.imem_req && ($urandom_range(99) < p_ack);
        do_ready = ($urandom_range(99) < p_ready);
        do_redir = force_redir || ($urandom_range(99) < p_redir);
        tgt      = force_redir ? force_tgt : pick_target();
        rdata    = $urandom;
        if (do_redir && tgt[1:0] != 2'b00) do_ready = 1'b0;
        if (!model_halted) begin
            if (do_redir) begin
                if (bus.imem_req) discard = 1'b1;
                if (tgt[1:0] != 2'b00) begin
                    model_fault  = 1'b1;
                    model_halted = 1'b1;
                end else begin
                    model_pc = tgt;
                end
            end else if (bus.instr_valid && do_ready) begin
                model_pc = model_pc + 32'd4;
            end
            if (bus.instr_valid && do_ready) begin
                model_acc++;
                if (halt_lvl) model_halted = 1'b1;
            end
            if (do_ack) begin
                if (!discard && !do_redir && !model_halted) sb.push_back('{rdata, req_exp_addr});
                discard  = 1'b0;
                req_open = 1'b0;
            end
        end
        bus.imem_ack        = do_ack;
        bus.imem_rdata      = rdata;
        bus.instr_ready     = do_ready;
        bus.redirect_valid  = do_redir;
        bus.redirect_target = do_redir ? tgt : $urandom;
        bus.halt            = halt_lvl;
    endtask

    // Asynchronous reset mid-cycle; reset values must appear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n               = 1'b0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.halt            = 1'b0;
        model_pc     = RV;
        req_open     = 1'b0;
        discard      = 1'b0;
        model_halted = 1'b0;
        model_fault  = 1'b0;
        halt_lvl     = 1'b0;
        model_acc    = 0;
        sb.delete();
        #1;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_fault", {31'h0, bus.fault}, 32'h0);
        chk("rst_addr", bus.imem_addr, RV);
        chk("rst_out", bus.instr_out, 32'h0);
        chk("rst_ipc", bus.instr_pc, 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Let any presented instruction be accepted without starting new fetches.
    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            step(0, 100, 0);
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        chk("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    // Monitor: retire entries on accept/cancel, compare presented instruction.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
            exp_count  = '0;
        end else begin
            if (prev_valid && sb.size() > 0) begin
                if (bus.instr_ready) begin
                    void'(sb.pop_front());
                    exp_count = exp_count + 32'd1;
                end else if (bus.redirect_valid) begin
                    void'(sb.pop_front());
                end
            end
            if (bus.instr_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", {31'h0, bus.instr_valid}, 32'h0);
                end else begin
                    chk("instr_out", bus.instr_out, sb[0].data);
                    chk("instr_pc", bus.instr_pc, sb[0].pc);
                end
            end
            chk("fetch_count", bus.fetch_count, exp_count);
            prev_valid = bus.instr_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.halt            = 1'b0;
        prev_valid          = 1'b0;
        exp_count           = '0;

        // Zero-wait memory, always-ready decode: 0x100, 0x104, 0x108.
        do_reset();
        for (int i = 0; i < 30 && model_acc < 3; i++) step(100, 100, 0);
        @(posedge clk);
        #2;
        chk("count_after_3", bus.fetch_count, 32'd3);
        drain();

        // Random ack latency, decode back-pressure and aligned redirects.
        for (int i = 0; i < 300; i++) step(40, 50, 8);
        drain();

        // Wrap through the top of the address space.
        step(100, 100, 0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) step(100, 100, 0);
        drain();

        // Misaligned redirect while a fetch is outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 0, 0, 1'b1, 32'h0000_0202);
        for (int i = 0; i < 10; i++) step(100, 100, 0);
        chk("fault_sticky", {31'h0, bus.fault}, 32'h1);

        // Halt raised mid-fetch: current instruction still delivered.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        halt_lvl = 1'b1;
        for (int i = 0; i < 2; i++) step(0, 0, 0);
        for (int i = 0; i < 15; i++) step(100, 100, 0);
        chk("halt_delivered", bus.fetch_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
